// File: rtl/i2d_opsched_if.sv
// Decode-to-scheduler bundle for the i2d operand scheduler, plus the operand mux select encodings.
// Decode drives the master side; the scheduler (i2d_opsched) sits on the slave side.

`ifndef I2D_OPMUX_A_RA
`define I2D_OPMUX_A_RA    2'd0
`define I2D_OPMUX_A_ID_PC 2'd1
`define I2D_OPMUX_A_ZERO  2'd2
`endif

`ifndef I2D_OPMUX_B_RB
`define I2D_OPMUX_B_RB    2'd0
`define I2D_OPMUX_B_IMM   2'd1
`define I2D_OPMUX_B_FOUR  2'd2
`endif

interface i2d_opsched_if #(
    parameter int RIDX_W = 5,
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic              id_ready;
    logic [1:0]        id_asrc;
    logic [1:0]        id_bsrc;
    logic [RIDX_W-1:0] id_ra_idx;
    logic [RIDX_W-1:0] id_rb_idx;
    logic [RIDX_W-1:0] id_rd_idx;
    logic              id_wen;
    logic              id_is_load;
    logic              flush;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_asrc, id_bsrc, id_ra_idx, id_rb_idx, id_rd_idx,
               id_wen, id_is_load, flush,
        input  id_ready, sel_a, sel_b, fwd_a, fwd_b, stall_cycles
    );

    modport slave (
        input  id_valid, id_asrc, id_bsrc, id_ra_idx, id_rb_idx, id_rd_idx,
               id_wen, id_is_load, flush,
        output id_ready, sel_a, sel_b, fwd_a, fwd_b, stall_cycles
    );
endinterface

// File: rtl/i2d_opsched.sv
// Operand scheduler: EX/MEM write scoreboard, load-use stall and forwarding selects at decode.
// Optional stall counter enabled by defining I2D_OPSCHED_PERF_EN.

module i2d_opsched #(
    parameter int RIDX_W = 5,
    parameter int PERF_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    i2d_opsched_if.slave  bus
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic              r_exValid;
    logic [RIDX_W-1:0] r_exRd;
    logic              r_exLoad;
    logic              r_memValid;
    logic [RIDX_W-1:0] r_memRd;
    logic              r_memLoad;

    logic w_aCheck, w_bCheck;
    logic w_aExHit, w_bExHit;
    logic w_aMemHit, w_bMemHit;
    logic w_aLoadUse, w_bLoadUse;
    logic w_ready;
    logic w_issue;
    logic w_exWrite;
    logic [1:0] w_fwdA, w_fwdB;

    // Only register-sourced operands with a non-zero index can be hazards.
    assign w_aCheck = (bus.id_asrc == `I2D_OPMUX_A_RA) && (bus.id_ra_idx != '0);
    assign w_bCheck = (bus.id_bsrc == `I2D_OPMUX_B_RB) && (bus.id_rb_idx != '0);

    assign w_aExHit  = w_aCheck && r_exValid  && (r_exRd  == bus.id_ra_idx);
    assign w_bExHit  = w_bCheck && r_exValid  && (r_exRd  == bus.id_rb_idx);
    assign w_aMemHit = w_aCheck && r_memValid && (r_memRd == bus.id_ra_idx);
    assign w_bMemHit = w_bCheck && r_memValid && (r_memRd == bus.id_rb_idx);

    assign w_aLoadUse = w_aExHit && r_exLoad;
    assign w_bLoadUse = w_bExHit && r_exLoad;

    assign w_ready   = rst && !(w_aLoadUse || w_bLoadUse);
    assign w_issue   = bus.id_valid && w_ready;
    assign w_exWrite = w_issue && !bus.flush && bus.id_wen && (bus.id_rd_idx != '0);

    // Youngest producer wins; a stalled operand reads the regfile path until the load reaches MEM.
    always_comb begin
        w_fwdA = FWD_RF;
        w_fwdB = FWD_RF;
        if (rst) begin
            if (w_aExHit) begin
                w_fwdA = r_exLoad ? FWD_RF : FWD_EX;
            end else if (w_aMemHit) begin
                w_fwdA = FWD_MEM;
            end
            if (w_bExHit) begin
                w_fwdB = r_exLoad ? FWD_RF : FWD_EX;
            end else if (w_bMemHit) begin
                w_fwdB = FWD_MEM;
            end
        end
    end

    assign bus.id_ready = w_ready;
    assign bus.sel_a    = bus.id_asrc;
    assign bus.sel_b    = bus.id_bsrc;
    assign bus.fwd_a    = w_fwdA;
    assign bus.fwd_b    = w_fwdB;

    // MEM always takes the old EX; EX takes a bubble on stall, flush or non-writing issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exValid  <= 1'b0;
            r_exRd     <= '0;
            r_exLoad   <= 1'b0;
            r_memValid <= 1'b0;
            r_memRd    <= '0;
            r_memLoad  <= 1'b0;
        end else begin
            r_memValid <= r_exValid;
            r_memRd    <= r_exRd;
            r_memLoad  <= r_exLoad;
            if (w_exWrite) begin
                r_exValid <= 1'b1;
                r_exRd    <= bus.id_rd_idx;
                r_exLoad  <= bus.id_is_load;
            end else begin
                r_exValid <= 1'b0;
                r_exRd    <= '0;
                r_exLoad  <= 1'b0;
            end
        end
    end

`ifdef I2D_OPSCHED_PERF_EN
    logic [PERF_W-1:0] r_stallCycles;

    // Saturating count of cycles where decode waits on the scheduler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stallCycles <= '0;
        end else if (bus.id_valid && !w_ready && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 1'b1;
        end
    end

    assign bus.stall_cycles = r_stallCycles;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_i2d_opsched.sv
// Directed self-checking bench for i2d_opsched: forwarding, load-use stall, flush and reset cases.
// Expected stall_cycles follows I2D_OPSCHED_PERF_EN.

module tb_i2d_opsched;

    localparam int RIDX_W = 5;
    localparam int PERF_W = 32;

    localparam logic [1:0] A_RA    = 2'd0;
    localparam logic [1:0] A_ID_PC = 2'd1;
    localparam logic [1:0] B_RB    = 2'd0;
    localparam logic [1:0] B_IMM   = 2'd1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    i2d_opsched_if #(.RIDX_W(RIDX_W), .PERF_W(PERF_W)) bus ();

    i2d_opsched #(.RIDX_W(RIDX_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one decode-side vector; called shortly after a rising edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] asrc, input int ra,
                                 input logic [1:0] bsrc, input int rb, input int rd,
                                 input logic wen, input logic ld, input logic fl);
        bus.id_valid   = valid;
        bus.id_asrc    = asrc;
        bus.id_bsrc    = bsrc;
        bus.id_ra_idx  = RIDX_W'(ra);
        bus.id_rb_idx  = RIDX_W'(rb);
        bus.id_rd_idx  = RIDX_W'(rd);
        bus.id_wen     = wen;
        bus.id_is_load = ld;
        bus.flush      = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkSched(input string tag, input logic rdy, input logic [1:0] fa,
                              input logic [1:0] fb);
        @(negedge clk);
        checkOutput({tag, ".id_ready"}, 32'(bus.id_ready), 32'(rdy));
        checkOutput({tag, ".fwd_a"},    32'(bus.fwd_a),    32'(fa));
        checkOutput({tag, ".fwd_b"},    32'(bus.fwd_b),    32'(fb));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expStall;

    initial begin
        total = 0;
        bad   = 0;
`ifdef I2D_OPSCHED_PERF_EN
        expStall = 32'd1;
`else
        expStall = 32'd0;
`endif
        rst = 1'b0;
        applyStimulus(1'b1, A_RA, 3, B_RB, 4, 6, 1'b1, 1'b0, 1'b0);
        checkSched("reset", 1'b0, 2'b00, 2'b00);
        checkOutput("reset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b1;

        // ADD r3 then SUB reading r3 -> EX forward
        applyStimulus(1'b1, A_RA, 1, B_RB, 2, 3, 1'b1, 1'b0, 1'b0);
        checkSched("add_r3", 1'b1, 2'b00, 2'b00);
        checkOutput("add_r3.sel_a", 32'(bus.sel_a), 32'(A_RA));
        nextCycle();
        applyStimulus(1'b1, A_RA, 3, B_RB, 4, 6, 1'b1, 1'b0, 1'b0);
        checkSched("sub_r3", 1'b1, 2'b01, 2'b00);
        nextCycle();

        // A hits EX (r6), B hits MEM (r3) independently
        applyStimulus(1'b1, A_RA, 6, B_RB, 3, 0, 1'b0, 1'b0, 1'b0);
        checkSched("split", 1'b1, 2'b01, 2'b10);
        nextCycle();

        // LW r5 then consumer of r5 on B -> one stall, then MEM forward
        applyStimulus(1'b1, A_RA, 1, B_RB, 0, 5, 1'b1, 1'b1, 1'b0);
        checkSched("lw_r5", 1'b1, 2'b00, 2'b00);
        nextCycle();
        applyStimulus(1'b1, A_RA, 1, B_RB, 5, 8, 1'b1, 1'b0, 1'b0);
        checkSched("loaduse", 1'b0, 2'b00, 2'b00);
        nextCycle();
        checkSched("loaduse_go", 1'b1, 2'b00, 2'b10);
        checkOutput("loaduse.stall_cycles", 32'(bus.stall_cycles), expStall);
        nextCycle();

        // ADD r0 then consumer of r0
        applyStimulus(1'b1, A_RA, 1, B_RB, 2, 0, 1'b1, 1'b0, 1'b0);
        checkSched("add_r0", 1'b1, 2'b00, 2'b00);
        nextCycle();
        applyStimulus(1'b1, A_RA, 0, B_RB, 0, 0, 1'b0, 1'b0, 1'b0);
        checkSched("use_r0", 1'b1, 2'b00, 2'b00);
        nextCycle();

        // Non-register sources ignore a pending r3
        applyStimulus(1'b1, A_RA, 1, B_RB, 2, 3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, A_ID_PC, 3, B_IMM, 3, 0, 1'b0, 1'b0, 1'b0);
        checkSched("pc_imm", 1'b1, 2'b00, 2'b00);
        checkOutput("pc_imm.sel_a", 32'(bus.sel_a), 32'(A_ID_PC));
        checkOutput("pc_imm.sel_b", 32'(bus.sel_b), 32'(B_IMM));
        nextCycle();

        // ADD r7 with flush: EX slot killed
        applyStimulus(1'b1, A_RA, 1, B_RB, 2, 7, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, A_RA, 7, B_RB, 7, 0, 1'b0, 1'b0, 1'b0);
        checkSched("flush_r7", 1'b1, 2'b00, 2'b00);
        nextCycle();

        // Flush still lets the old EX entry advance to MEM
        applyStimulus(1'b1, A_RA, 1, B_RB, 2, 9, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, A_RA, 9, B_RB, 1, 0, 1'b0, 1'b0, 1'b1);
        checkSched("flush_ex9", 1'b1, 2'b01, 2'b00);
        nextCycle();
        applyStimulus(1'b1, A_RA, 9, B_RB, 1, 0, 1'b0, 1'b0, 1'b0);
        checkSched("mem9", 1'b1, 2'b10, 2'b00);
        nextCycle();

        // LW r2 then reset mid-operation
        applyStimulus(1'b1, A_RA, 1, B_RB, 1, 2, 1'b1, 1'b1, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, A_RA, 2, B_RB, 2, 0, 1'b0, 1'b0, 1'b0);
        checkSched("midreset", 1'b0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("midreset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b1;
        checkSched("after_reset", 1'b1, 2'b00, 2'b00);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
